// File: rtl/fifo_stream_reader.sv
// Purpose : drains a fixed-latency FIFO read port into a ready/valid stream via a local skid buffer.
// Latency : first word on m_valid LATENCY+1 cycles after the first request; one word/cycle sustained.
// Backpressure: requests are throttled so in-flight + buffered words never exceed DEPTH = LATENCY+1.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fifo_empty                FIFO empty flag; no request is issued while high
//   fifo_request_output       FIFO read request (combinational, forced low during rst)
//   fifo_data_out/_output_valid  FIFO read data, returned LATENCY cycles after a request
//   m_data, m_valid, m_ready  output stream (data/valid held stable while stalled)
//   m_last                    last beat of a PACKET_LEN-word packet (FIFO_STREAM_READER_LAST_EN only)
//   error                     sticky: unexpected read-valid or buffer overflow, cleared by rst
//
// Optional feature macro: FIFO_STREAM_READER_LAST_EN adds the m_last port and its beat counter.
module fifo_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 3,
  parameter int PACKET_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_request_output,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_output_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef FIFO_STREAM_READER_LAST_EN
  output logic             m_last,
`endif
  output logic             error
);

  localparam int DEPTH = LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [WIDTH-1:0] mem [DEPTH];

  logic        pop;
  logic        stale;
  logic        overflow;
  logic        accept;
  logic        capture;
  logic [CW:0] outstanding;

  assign pop = m_valid & m_ready;

  // Evaluated one bit wider than the counters so the subtraction of pop
  // cannot wrap; pop frees a slot in the same cycle, which keeps the
  // pipeline full when the consumer resumes.
  assign outstanding = {1'b0, in_flight} + {1'b0, count} - {{CW{1'b0}}, pop};

  assign fifo_request_output = ~rst & ~fifo_empty & (outstanding < DEPTH_W);

  // A returning word with nothing in flight is a stale pulse (e.g. from
  // before reset) and is dropped. A word that finds the buffer full with no
  // pop is dropped too; both flag error.
  assign stale    = fifo_output_valid & (in_flight == '0);
  assign accept   = fifo_output_valid & ~stale;
  assign overflow = accept & (count == DEPTH_C) & ~pop;
  assign capture  = accept & ~overflow;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      error     <= 1'b0;
    end else begin
      in_flight <= in_flight + CW'(fifo_request_output) - CW'(accept);
      if (capture) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stale | overflow) error <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (capture) mem[tail] <= fifo_data_out;
  end

  assign m_valid = (count != '0);
  assign m_data  = mem[head];

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(PACKET_LEN - 1);

  logic [BW-1:0] beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
    end
  end

  assign m_last = m_valid & (beat == BEAT_MAX);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fixed-latency FIFO model feeding the DUT,
// scoreboard of words loaded into the FIFO compared against stream beats in order.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_stream_reader;

  localparam int W = 8;
  localparam int L = 3;
`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int PLEN = 4;
`else
  localparam int PLEN = 16;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_request_output;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_output_valid = 1'b0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         error;
`ifdef FIFO_STREAM_READER_LAST_EN
  logic         m_last;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(W), .LATENCY(L), .PACKET_LEN(PLEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_empty          (fifo_empty),
    .fifo_request_output (fifo_request_output),
    .fifo_data_out       (fifo_data_out),
    .fifo_output_valid   (fifo_output_valid),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
`ifdef FIFO_STREAM_READER_LAST_EN
    .m_last              (m_last),
`endif
    .error               (error)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         pv[L];
  logic [W-1:0] pd[L];

  int cyc_cnt = 0;
  int req_cnt = 0;
  int beat_cnt = 0;
  int first_beat_cyc = -1;
  int last_beat_cyc = 0;
  int gaps = 0;
  int pkt_idx = 0;

  logic         inject = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_rst = 1'b1;
  logic [W-1:0] prev_dat = '0;
  logic         s_req = 1'b0;
  logic         s_mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = W'($urandom);
      fifo_q.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  task automatic clr();
    req_cnt = 0;
    beat_cnt = 0;
    first_beat_cyc = -1;
    last_beat_cyc = 0;
    gaps = 0;
  endtask

  // One clock cycle: drive DUT inputs and the FIFO model's read port, sample,
  // score any beat, then advance the FIFO read-latency pipeline.
  task automatic cyc(input logic rdy, input logic r);
    logic         beat;
    logic [W-1:0] nd;
    @(negedge clk);
    rst               = r;
    m_ready           = rdy;
    fifo_empty        = (fifo_q.size() == 0);
    fifo_output_valid = pv[L-1] | inject;
    fifo_data_out     = inject ? W'(8'hA5) : pd[L-1];
    #1;
    s_req    = fifo_request_output;
    s_mvalid = m_valid;
    beat     = m_valid & m_ready;
    if (!r) begin
      if (fifo_empty) chk("req_while_empty", 32'(fifo_request_output), 32'd0);
      if (prev_stall && !prev_rst) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_dat));
      end
      if (beat) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("data", 32'(m_data), 32'(exp_q.pop_front()));
`ifdef FIFO_STREAM_READER_LAST_EN
        chk("m_last", 32'(m_last), 32'(pkt_idx == PLEN - 1));
`endif
        pkt_idx = (pkt_idx + 1) % PLEN;
        if (first_beat_cyc < 0) first_beat_cyc = cyc_cnt;
        else if (cyc_cnt - last_beat_cyc > 1) gaps++;
        last_beat_cyc = cyc_cnt;
        beat_cnt++;
      end
    end else begin
      pkt_idx = 0;
    end
    prev_stall = m_valid & ~m_ready;
    prev_dat   = m_data;
    prev_rst   = r;
    nd = '0;
    if (fifo_request_output) begin
      req_cnt++;
      if (fifo_q.size() != 0) nd = fifo_q.pop_front();
    end
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = fifo_request_output;
    pd[0] = nd;
    cyc_cnt++;
  endtask

  initial begin
    int t0;
    int pushed;
    int n;
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    // Reset with 5 words preloaded: nothing requested or presented during rst.
    load(5);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_m_valid", 32'(s_mvalid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
`ifdef FIFO_STREAM_READER_LAST_EN
    chk("rst_m_last", 32'(m_last), 32'd0);
`endif

    // First word 4 cycles after rst falls, 5 back-to-back beats, 5 requests.
    clr();
    t0 = cyc_cnt;
    repeat (12) cyc(1'b1, 1'b0);
    chk("t1_latency", 32'(first_beat_cyc - t0), 32'd4);
    chk("t1_beats", 32'(beat_cnt), 32'd5);
    chk("t1_gaps", 32'(gaps), 32'd0);
    chk("t1_reqs", 32'(req_cnt), 32'd5);
    chk("t1_error", 32'(error), 32'd0);

    // 100 words at full rate: no bubble after the first beat.
    load(100);
    clr();
    repeat (110) cyc(1'b1, 1'b0);
    chk("t2_beats", 32'(beat_cnt), 32'd100);
    chk("t2_gaps", 32'(gaps), 32'd0);
    chk("t2_reqs", 32'(req_cnt), 32'd100);

    // Stall for 20 cycles mid-stream: exactly DEPTH words outstanding.
    load(40);
    clr();
    repeat (10) cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    chk("t3_outstanding", 32'(req_cnt - beat_cnt), 32'd4);
    chk("t3_req_off", 32'(s_req), 32'd0);
    chk("t3_m_valid", 32'(s_mvalid), 32'd1);
    cyc(1'b1, 1'b0);
    chk("t3_resume_req", 32'(s_req), 32'd1);
    gaps = 0;
    repeat (50) cyc(1'b1, 1'b0);
    chk("t3_beats", 32'(beat_cnt), 32'd40);
    chk("t3_resume_gaps", 32'(gaps), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure and random FIFO refill, 1000 words.
    clr();
    pushed = 0;
    for (int c = 0; c < 20000 && beat_cnt < 1000; c++) begin
      if (pushed < 1000 && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 4);
        if (n > 1000 - pushed) n = 1000 - pushed;
        load(n);
        pushed += n;
      end
      cyc($urandom_range(0, 99) < 30, 1'b0);
    end
    chk("t4_beats", 32'(beat_cnt), 32'd1000);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_error", 32'(error), 32'd0);

    // Read-valid with nothing in flight: sticky error, word discarded.
    repeat (5) cyc(1'b1, 1'b0);
    inject = 1'b1;
    cyc(1'b1, 1'b0);
    inject = 1'b0;
    cyc(1'b1, 1'b0);
    chk("t5_error_set", 32'(error), 32'd1);
    chk("t5_m_valid", 32'(s_mvalid), 32'd0);
    repeat (10) cyc(1'b1, 1'b0);
    chk("t5_error_held", 32'(error), 32'd1);
    chk("t5_m_valid_held", 32'(s_mvalid), 32'd0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("t5_error_cleared", 32'(error), 32'd0);

`ifdef FIFO_STREAM_READER_LAST_EN
    // Framing: 12 words give m_last on beats 3, 7, 11 (checked per beat).
    clr();
    load(12);
    repeat (25) cyc(1'b1, 1'b0);
    chk("t6_beats", 32'(beat_cnt), 32'd12);
    // Reset after a partial packet: the counter restarts at 0.
    load(5);
    repeat (15) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    clr();
    load(4);
    repeat (12) cyc(1'b1, 1'b0);
    chk("t6_post_rst_beats", 32'(beat_cnt), 32'd4);
    chk("t6_pkt_idx", 32'(pkt_idx), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
